// File: rtl/program_sequencer_pkg.sv
// Shared types and helpers for the program sequencer and its return stack.
package seq_pkg;

    // Where the next PC comes from, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SRC_INIT,
        SRC_HOLD,
        SRC_RET,
        SRC_CALL,
        SRC_BRANCH,
        SRC_INC
    } next_src_t;

    // Widest PC the helper below supports; callers truncate the result.
    localparam int ADDR_MAX_W = 32;

    // Relative target. The low PC_W bits of the sum are the same whether JP
    // is sign- or zero-extended, so a plain add followed by truncation gives
    // PC + signed(JP) modulo 2^PC_W.
    function automatic logic [ADDR_MAX_W-1:0] rel_target(
        input logic [ADDR_MAX_W-1:0] pc,
        input logic [ADDR_MAX_W-1:0] jp
    );
        return pc + jp;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Control/status bundle between the decoder/branch logic and the sequencer.
//
// Signalling: there is no valid/ready handshake. Every control is a level that
// is sampled on each rising clock edge; the sequencer is always ready and
// every status output is a register that changes one cycle after sampling.
interface program_sequencer_if #(
    parameter int PC_W    = 9,
    parameter int DEPTH_W = 3
);
    logic              Init;
    logic              Halt;
    logic              Branch;
    logic              BrRel;
    logic [PC_W-1:0]   JP;
    logic              Call;
    logic              Ret;
    logic [PC_W-1:0]   PC;
    logic              Done;
    logic [DEPTH_W-1:0] Depth;
    logic              StackErr;

    // Decoder / branch logic side.
    modport master (
        output Init, Halt, Branch, BrRel, JP, Call, Ret,
        input  PC, Done, Depth, StackErr
    );

    // Sequencer side.
    modport slave (
        input  Init, Halt, Branch, BrRel, JP, Call, Ret,
        output PC, Done, Depth, StackErr
    );
endinterface

// File: rtl/program_sequencer_stack.sv
// LIFO of return addresses with a combinational top-of-stack read.
module pc_return_stack #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int DEPTH_W = $clog2(DEPTH + 1),
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_W-1:0] sp;
    logic [IDX_W-1:0]   top_idx;

    assign full    = (sp == DEPTH_W'(DEPTH));
    assign empty   = (sp == '0);
    assign depth   = sp;
    assign top_idx = IDX_W'(sp - DEPTH_W'(1));
    assign dout    = empty ? '0 : mem[top_idx];

    // Stack pointer: clear wins, push/pop on a full/empty stack are ignored.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + DEPTH_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - DEPTH_W'(1);
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge CLK) begin
        if (push && !full && !clear) begin
            mem[IDX_W'(sp)] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction-address generator: PC register, priority select, Done flag,
// sticky stack error, and a hardware return stack for call/return.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input logic               CLK,
    input logic               Reset,
    program_sequencer_if.slave bus
);

    localparam logic [PC_W-1:0] RESET_VAL = PC_W'(RESET_PC);

    next_src_t        src;
    logic [PC_W-1:0]  pc_q;
    logic             done_q;
    logic             err_q;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  st_dout;
    logic             st_full;
    logic             st_empty;
    logic             push;
    logic             pop;
    logic             clear;

    assign pc_inc = pc_q + PC_W'(1);
    assign target = bus.BrRel
                  ? PC_W'(rel_target(ADDR_MAX_W'(pc_q), ADDR_MAX_W'(bus.JP)))
                  : bus.JP;

    // Priority encoder: Init > Halt > Ret > Call > Branch > increment.
    always_comb begin
        src = SRC_INC;
        if (bus.Init)        src = SRC_INIT;
        else if (bus.Halt)   src = SRC_HOLD;
        else if (bus.Ret)    src = SRC_RET;
        else if (bus.Call)   src = SRC_CALL;
        else if (bus.Branch) src = SRC_BRANCH;
    end

    assign clear = (src == SRC_INIT);
    assign push  = (src == SRC_CALL);
    assign pop   = (src == SRC_RET);

    pc_return_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .Reset (Reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (st_dout),
        .depth (bus.Depth),
        .full  (st_full),
        .empty (st_empty)
    );

    // PC, Done and sticky StackErr update according to the winning source.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q   <= RESET_VAL;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (src)
                SRC_INIT: begin
                    pc_q  <= RESET_VAL;
                    err_q <= 1'b0;
                end
                SRC_HOLD: begin
                    done_q <= 1'b1;
                end
                SRC_RET: begin
                    if (!st_empty) begin
                        pc_q <= st_dout;
                    end else begin
                        pc_q  <= pc_inc;
                        err_q <= 1'b1;
                    end
                end
                SRC_CALL: begin
                    if (!st_full) begin
                        pc_q <= target;
                    end else begin
                        pc_q  <= pc_inc;
                        err_q <= 1'b1;
                    end
                end
                SRC_BRANCH: pc_q <= target;
                default:    pc_q <= pc_inc;
            endcase
        end
    end

    assign bus.PC       = pc_q;
    assign bus.Done     = done_q;
    assign bus.StackErr = err_q;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Parametrised successor to the fetch-stage program counter. Generates the instruction address each cycle and supports:
- absolute and PC-relative branches
- subroutine call/return through an internal hardware return stack
- halt with a registered Done flag
- sticky stack-error reporting

It sits between the decoder/branch logic and the instruction ROM. The PC output drives the ROM address directly.

Parameters:
PC_W, 9, PC and jump-operand width in bits
STACK_DEPTH, 4, return-stack entries (>=1)
RESET_PC, 0, PC value loaded by Reset and Init
DEPTH_W, $clog2(STACK_DEPTH+1), width of Depth output (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous active-high reset
Init  in  1  synchronous re-initialise (same effect as Reset, at the clock edge)
Halt  in  1  freeze PC
Branch  in  1  take jump to target
BrRel  in  1  1: target = PC + JP (JP signed two's complement); 0: target = JP
JP  in  PC_W  absolute address or signed offset
Call  in  1  push PC+1, then jump to target (BrRel applies)
Ret  in  1  pop top of stack into PC
PC  out  PC_W  current instruction address
Done  out  1  registered halt indication
Depth  out  DEPTH_W  current stack occupancy
StackErr  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (asynchronous, immediate, takes effect mid-operation):
  - PC=RESET_PC, stack pointer=0, Depth=0, Done=0, StackErr=0.
  - Stack contents are don't-care.
- Per rising edge, the first matching condition in this priority order wins:
  1. Init: same result as Reset.
  2. Halt: PC holds, stack unchanged, Done<=1.
  3. Ret:
     - Depth>0: PC<=top entry, Depth<=Depth-1.
     - Depth==0 (underflow): PC<=PC+1, StackErr<=1.
  4. Call:
     - Depth<STACK_DEPTH: push PC+1, Depth<=Depth+1, PC<=target.
     - Depth full (overflow): no push, PC<=PC+1, StackErr<=1.
  5. Branch: PC<=target.
  6. Otherwise: PC<=PC+1.
- Done: Done<=0 on every edge whose winning case is not Halt. Done therefore rises exactly one cycle after Halt is first sampled and falls one cycle after Halt deasserts.
- Simultaneous requests: Call+Ret together means Ret wins and Call is ignored. Branch is ignored whenever Call or Ret wins.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W.
  - PC+1 at all-ones wraps to 0.
  - Relative target = PC + JP (PC_W-bit add, carry discarded). Example: JP = all-ones gives PC-1.
  - Pushed return address = PC+1, also wrapped.
- StackErr is cleared only by Reset or Init.
- Latency:
  - PC updates one cycle after controls are sampled.
  - A pop/push is visible on Depth in the same cycle as the new PC.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package seq_pkg holds:
  - enum next_src_t {SRC_INIT, SRC_HOLD, SRC_RET, SRC_CALL, SRC_BRANCH, SRC_INC}
  - a function computing the relative target
- One sub-module, pc_return_stack (LIFO), with:
  - parameters WIDTH, DEPTH
  - ports CLK, Reset, push, pop, din, dout (top of stack, combinational read), depth, full, empty
- The top level holds the priority encoder, the PC register, Done and StackErr.

Test Plan (PC_W=9, STACK_DEPTH=4, RESET_PC=0):
1. Reset asserted mid-count at PC=37 with no clock edge -> PC=0, Depth=0, Done=0 immediately. Release, 3 idle cycles -> PC=1,2,3.
2. Relative and absolute branches:
   - At PC=10: Branch+BrRel with JP=9'h1FE (-2) -> PC=8.
   - Then Branch+BrRel=0 with JP=511 -> PC=511.
   - Next idle cycle -> PC=0 (wrap).
3. Nested calls/returns:
   - At PC=5, Call with JP=100 -> PC=100, Depth=1.
   - At PC=100, Call with JP=200 -> PC=200, Depth=2.
   - Ret -> PC=101, Depth=1. Ret -> PC=6, Depth=0. StackErr stays 0.
4. Overflow and underflow:
   - 4 Calls fill the stack. A 5th Call at PC=p -> PC=p+1, Depth=4, StackErr=1.
   - 4 Rets restore the correct addresses. A 5th Ret -> PC+1, StackErr stays 1.
   - Init -> StackErr=0, PC=0.
5. Halt/priority:
   - At PC=20, Halt+Branch+Call held 3 cycles -> PC stays 20, Depth unchanged, Done=0,1,1.
   - Drop Halt with Branch JP=50 -> PC=50, Done=0 on the same edge.
6. Simultaneous Call+Ret with Depth=1 (top=7) -> PC=7, Depth=0, no push.
